// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared pixel/window types and sizing helpers for the 2x2 max-pool unit
package maxpool_pkg;

    typedef logic signed [7:0] pixel_t;
    typedef pixel_t [1:0][1:0] window_t;

    localparam int DEFAULT_LENGTH = 28;

    function automatic int pool_len(input int length);
        return length / 2;
    endfunction

    // Width of an output (pooled) row/column index; never below one bit.
    function automatic int idx_width(input int length);
        return ($clog2(length / 2) < 1) ? 1 : $clog2(length / 2);
    endfunction

endpackage

// File: rtl/max2_signed.sv
// rtl/max2_signed.sv - combinational signed 8-bit two-input maximum
module max2_signed (
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    output logic signed [7:0] y
);

    assign y = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_unit.sv
// rtl/maxpool_unit.sv - stride-2 2x2 max-pool behind the line buffer, 2-stage compare pipeline
// Optional build macro: MAXPOOL_RELU_EN clamps negative pooled results to zero.
module maxpool_unit
    import maxpool_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH,
    localparam int IW = idx_width(LENGTH),
    localparam int CW = $clog2(LENGTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_valid_in,
    input  logic signed [1:0][1:0][7:0] window,
    output logic signed [7:0]           pool_out,
    output logic                        pool_valid_out,
    output logic [IW-1:0]               pool_col,
    output logic [IW-1:0]               pool_row,
    output logic                        frame_done
);

    logic [CW-1:0] col_cnt;
    logic [CW-1:0] row_cnt;
    logic          col_last;
    logic          row_last;
    logic          anchor;

    logic          anchor_d0, last_d0;
    logic [IW-1:0] col_d0, row_d0;
    logic          anchor_d1, last_d1;
    logic [IW-1:0] col_d1, row_d1;

    pixel_t        m0_next, m1_next, m0, m1;
    pixel_t        max_next, pool_next;

    assign col_last = (col_cnt == CW'(LENGTH - 1));
    assign row_last = (row_cnt == CW'(LENGTH - 1));
    assign anchor   = data_valid_in & col_cnt[0] & row_cnt[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (data_valid_in) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    max2_signed u_max_prev (.a(window[0][0]), .b(window[0][1]), .y(m0_next));
    max2_signed u_max_curr (.a(window[1][0]), .b(window[1][1]), .y(m1_next));
    max2_signed u_max_fin  (.a(m0),           .b(m1),           .y(max_next));

`ifdef MAXPOOL_RELU_EN
    assign pool_next = (max_next < 0) ? pixel_t'(0) : max_next;
`else
    assign pool_next = max_next;
`endif

    // Pipeline runs every cycle; stage 1 samples the window one edge after the anchor is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anchor_d0      <= 1'b0;
            last_d0        <= 1'b0;
            col_d0         <= '0;
            row_d0         <= '0;
            anchor_d1      <= 1'b0;
            last_d1        <= 1'b0;
            col_d1         <= '0;
            row_d1         <= '0;
            m0             <= '0;
            m1             <= '0;
            pool_out       <= '0;
            pool_valid_out <= 1'b0;
            pool_col       <= '0;
            pool_row       <= '0;
            frame_done     <= 1'b0;
        end else begin
            anchor_d0      <= anchor;
            last_d0        <= anchor & col_last & row_last;
            col_d0         <= IW'(col_cnt >> 1);
            row_d0         <= IW'(row_cnt >> 1);
            anchor_d1      <= anchor_d0;
            last_d1        <= last_d0;
            col_d1         <= col_d0;
            row_d1         <= row_d0;
            m0             <= m0_next;
            m1             <= m1_next;
            pool_valid_out <= anchor_d1;
            frame_done     <= last_d1;
            if (anchor_d1) begin
                pool_out <= pool_next;
                pool_col <= col_d1;
                pool_row <= row_d1;
            end
        end
    end

`ifndef SYNTHESIS
    if ((LENGTH % 2) != 0 || LENGTH < 4) begin : g_bad_length
        $error("maxpool_unit: LENGTH must be even and at least 4");
    end

    assert property (@(posedge clk) disable iff (rst)
        !(pool_valid_out && $past(pool_valid_out)))
        else $error("maxpool_unit: pool_valid_out high on consecutive cycles");
`endif

endmodule

// File: tb/tb_maxpool_unit.sv
// tb/tb_maxpool_unit.sv - randomized self-checking bench for maxpool_unit against a frame-level model
module tb_maxpool_unit;

    localparam int L  = 4;
    localparam int IW = (($clog2(L / 2)) < 1) ? 1 : $clog2(L / 2);

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        data_valid_in;
    logic signed [1:0][1:0][7:0] window;
    logic signed [7:0]           pool_out;
    logic                        pool_valid_out;
    logic [IW-1:0]               pool_col;
    logic [IW-1:0]               pool_row;
    logic                        frame_done;

    maxpool_unit #(.LENGTH(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_valid_in  (data_valid_in),
        .window         (window),
        .pool_out       (pool_out),
        .pool_valid_out (pool_valid_out),
        .pool_col       (pool_col),
        .pool_row       (pool_row),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int val;
        int col;
        int row;
        int done;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   img [L][L];
    int   pcount   = 0;
    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int rnd_pix();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // One clock: present the pixel, let the line buffer (modelled here) update, log any output.
    task automatic step(input bit v, input int pix);
        int r, c, w00, w01, w10, w11, mx;
        data_valid_in = v;
        @(posedge clk);
        edge_cnt++;
        r = pcount / L;
        c = pcount % L;
        w00 = 0; w01 = 0; w10 = 0; w11 = 0;
        if (v) begin
            img[r][c] = pix;
            w11 = pix;
            w10 = (c > 0) ? img[r][c-1] : 0;
            w01 = (r > 0) ? img[r-1][c] : 0;
            w00 = (r > 0 && c > 0) ? img[r-1][c-1] : 0;
            if ((r % 2) == 1 && (c % 2) == 1) begin
                mx = w00;
                if (w01 > mx) mx = w01;
                if (w10 > mx) mx = w10;
                if (w11 > mx) mx = w11;
                exp_q.push_back('{edge_cnt + 2, relu(mx), c / 2, r / 2,
                                  (r == L-1 && c == L-1) ? 1 : 0});
            end
            pcount = (pcount + 1) % (L * L);
        end
        @(negedge clk);
        if (pool_valid_out === 1'b1)
            obs_q.push_back('{edge_cnt, int'(pool_out), int'(pool_col), int'(pool_row), int'(frame_done)});
        if (v) begin
            window[0][0] = 8'(w00);
            window[0][1] = 8'(w01);
            window[1][0] = 8'(w10);
            window[1][1] = 8'(w11);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) step(1'b0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid_in = 1'b0;
        window = '0;
        #1;
        n_cmp++; if (pool_out !== 8'sd0)     begin n_bad++; $display("FAIL reset_pool_out got %0d want 0", pool_out); end
        n_cmp++; if (pool_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", pool_valid_out); end
        n_cmp++; if (pool_col !== '0)         begin n_bad++; $display("FAIL reset_col got %0d want 0", pool_col); end
        n_cmp++; if (pool_row !== '0)         begin n_bad++; $display("FAIL reset_row got %0d want 0", pool_row); end
        n_cmp++; if (frame_done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", frame_done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        int e5;
        int want [4] = '{5, 7, 13, 15};
        exp_q.delete(); obs_q.delete();
        e5 = 0;
        for (int p = 0; p < 16; p++) begin
            step(1'b1, p);
            if (p == 5) e5 = edge_cnt;
        end
        flush();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 4) begin
            n_bad++; $display("FAIL ramp_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size() && i < 4; i++) begin
            n_cmp++;
            if (obs_q[i].t !== exp_q[i].t || obs_q[i].val !== exp_q[i].val || obs_q[i].col !== exp_q[i].col ||
                obs_q[i].row !== exp_q[i].row || obs_q[i].done !== exp_q[i].done) begin
                n_bad++; $display("FAIL ramp_out[%0d] got t%0d v%0d (%0d,%0d) d%0d want t%0d v%0d (%0d,%0d) d%0d", i,
                    obs_q[i].t, obs_q[i].val, obs_q[i].row, obs_q[i].col, obs_q[i].done,
                    exp_q[i].t, exp_q[i].val, exp_q[i].row, exp_q[i].col, exp_q[i].done);
            end
            n_cmp++;
            if (obs_q[i].val !== want[i] || obs_q[i].row !== i / 2 || obs_q[i].col !== i % 2) begin
                n_bad++; $display("FAIL ramp_const[%0d] got %0d at (%0d,%0d) want %0d at (%0d,%0d)", i,
                    obs_q[i].val, obs_q[i].row, obs_q[i].col, want[i], i / 2, i % 2);
            end
        end
        if (obs_q.size() > 0) begin
            n_cmp++;
            if (obs_q[0].t !== e5 + 2) begin
                n_bad++; $display("FAIL ramp_latency got edge %0d want %0d", obs_q[0].t, e5 + 2);
            end
        end
        if (obs_q.size() == 4) begin
            n_cmp++;
            if (obs_q[3].done !== 1 || obs_q[0].done !== 0) begin
                n_bad++; $display("FAIL ramp_frame_done got %0d/%0d want 0/1", obs_q[0].done, obs_q[3].done);
            end
        end
    endtask

    task automatic test_negative();
        exp_q.delete(); obs_q.delete();
        for (int p = 0; p < 16; p++) step(1'b1, -3);
        flush();
        n_cmp++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            n_bad++; $display("FAIL neg_count got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].val !== exp_q[i].val || obs_q[i].val !== relu(-3) || obs_q[i].t !== exp_q[i].t) begin
                n_bad++; $display("FAIL neg_out[%0d] got %0d at edge %0d want %0d at edge %0d", i,
                    obs_q[i].val, obs_q[i].t, relu(-3), exp_q[i].t);
            end
        end
    endtask

    task automatic test_signed();
        int pix [16];
        exp_q.delete(); obs_q.delete();
        for (int p = 0; p < 16; p++) pix[p] = rnd_pix();
        pix[0] = -128; pix[1] = 127; pix[4] = -1; pix[5] = 0;
        for (int p = 0; p < 16; p++) step(1'b1, pix[p]);
        flush();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || obs_q.size() == 0) begin
            n_bad++; $display("FAIL signed_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else if (obs_q[0].val !== 127) begin
            n_bad++; $display("FAIL signed_block got %0d want 127", obs_q[0].val);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].val !== exp_q[i].val || obs_q[i].col !== exp_q[i].col || obs_q[i].row !== exp_q[i].row) begin
                n_bad++; $display("FAIL signed_out[%0d] got %0d (%0d,%0d) want %0d (%0d,%0d)", i,
                    obs_q[i].val, obs_q[i].row, obs_q[i].col, exp_q[i].val, exp_q[i].row, exp_q[i].col);
            end
        end
    endtask

    task automatic test_gaps();
        int want [4] = '{5, 7, 13, 15};
        exp_q.delete(); obs_q.delete();
        for (int p = 0; p < 16; p++) begin
            step(1'b1, p);
            step(1'b0, 0);
        end
        flush();
        n_cmp++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            n_bad++; $display("FAIL gaps_count got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size() && i < 4; i++) begin
            n_cmp++;
            if (obs_q[i].t !== exp_q[i].t || obs_q[i].val !== want[i] || obs_q[i].row !== i / 2 ||
                obs_q[i].col !== i % 2 || obs_q[i].done !== exp_q[i].done) begin
                n_bad++; $display("FAIL gaps_out[%0d] got t%0d v%0d (%0d,%0d) want t%0d v%0d (%0d,%0d)", i,
                    obs_q[i].t, obs_q[i].val, obs_q[i].row, obs_q[i].col, exp_q[i].t, want[i], i / 2, i % 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        exp_q.delete(); obs_q.delete();
        for (int p = 0; p < 32; p++) step(1'b1, rnd_pix());
        flush();
        dones = 0;
        foreach (obs_q[i]) dones += obs_q[i].done;
        n_cmp++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            n_bad++; $display("FAIL b2b_count got %0d want 8", obs_q.size());
        end
        n_cmp++;
        if (dones !== 2) begin
            n_bad++; $display("FAIL b2b_frame_done got %0d want 2", dones);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].t !== exp_q[i].t || obs_q[i].val !== exp_q[i].val || obs_q[i].col !== exp_q[i].col ||
                obs_q[i].row !== exp_q[i].row || obs_q[i].done !== exp_q[i].done) begin
                n_bad++; $display("FAIL b2b_out[%0d] got t%0d v%0d (%0d,%0d) want t%0d v%0d (%0d,%0d)", i,
                    obs_q[i].t, obs_q[i].val, obs_q[i].row, obs_q[i].col,
                    exp_q[i].t, exp_q[i].val, exp_q[i].row, exp_q[i].col);
            end
        end
    endtask

    task automatic test_mid_reset();
        int e_rst;
        int keep [$];
        rec_t kept [$];
        exp_q.delete(); obs_q.delete();
        for (int p = 0; p < 10; p++) step(1'b1, p + 20);
        rst = 1'b1;
        data_valid_in = 1'b0;
        e_rst = edge_cnt;
        #1;
        n_cmp++;
        if (pool_out !== 8'sd0 || pool_valid_out !== 1'b0 || pool_col !== '0 || pool_row !== '0 || frame_done !== 1'b0) begin
            n_bad++; $display("FAIL midrst_async got v%0d val%0d (%0d,%0d) d%0d want all 0",
                pool_valid_out, pool_out, pool_row, pool_col, frame_done);
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        rst = 1'b0;
        pcount = 0;
        foreach (exp_q[i]) if (exp_q[i].t <= e_rst) kept.push_back(exp_q[i]);
        exp_q = kept;
        for (int p = 0; p < 16; p++) step(1'b1, rnd_pix());
        flush();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != kept.size() + 4) begin
            n_bad++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].t !== exp_q[i].t || obs_q[i].val !== exp_q[i].val || obs_q[i].col !== exp_q[i].col ||
                obs_q[i].row !== exp_q[i].row || obs_q[i].done !== exp_q[i].done) begin
                n_bad++; $display("FAIL midrst_out[%0d] got t%0d v%0d (%0d,%0d) want t%0d v%0d (%0d,%0d)", i,
                    obs_q[i].t, obs_q[i].val, obs_q[i].row, obs_q[i].col,
                    exp_q[i].t, exp_q[i].val, exp_q[i].row, exp_q[i].col);
            end
        end
    endtask

    task automatic test_random();
        int accepted;
        exp_q.delete(); obs_q.delete();
        accepted = 0;
        while (accepted < 3 * L * L) begin
            if ($urandom_range(0, 9) < 7) begin
                step(1'b1, rnd_pix());
                accepted++;
            end else begin
                step(1'b0, 0);
            end
        end
        flush();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || exp_q.size() != 12) begin
            n_bad++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].t !== exp_q[i].t || obs_q[i].val !== exp_q[i].val || obs_q[i].col !== exp_q[i].col ||
                obs_q[i].row !== exp_q[i].row || obs_q[i].done !== exp_q[i].done) begin
                n_bad++; $display("FAIL rand_out[%0d] got t%0d v%0d (%0d,%0d) d%0d want t%0d v%0d (%0d,%0d) d%0d", i,
                    obs_q[i].t, obs_q[i].val, obs_q[i].row, obs_q[i].col, obs_q[i].done,
                    exp_q[i].t, exp_q[i].val, exp_q[i].row, exp_q[i].col, exp_q[i].done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_signed();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
